tdm_deframer: RTL and testbench
===============================

# tdm_deframer

Receive-side deframer for the time-multiplexed shared-multiplier path. It accepts a serial stream of channel-tagged signed results, one channel per beat, in the Clock_20M domain. It reassembles each round of NUM_CH beats into one parallel frame and presents it with a valid/ready handshake. It also detects sequence breaks and stalled frames, so downstream logic never sees a partially updated channel set.

## Interface
Parameters:
- NUM_CH, 4, channels per frame (power of two, ≥2)
- DATA_W, 16, signed sample width
- TIMEOUT, 15, max idle cycles between beats inside a frame (≥1)

Ports:
- Clock_20M  input  1  block clock
- Ex_Rst_n  input  1  reset, asynchronous, active-low
- In_Valid  input  1  beat present
- In_Ready  output  1  beat accepted when In_Valid && In_Ready
- In_Chan  input  log2(NUM_CH)  channel tag of beat
- In_Data  input  DATA_W  signed sample
- Out_Valid  output  1  complete frame available
- Out_Ready  input  1  downstream accepts frame
- Out_Data  output  NUM_CH*DATA_W  frame; channel k at bits [k*DATA_W +: DATA_W]
- Seq_Err  output  1  one-cycle pulse: out-of-order beat
- Timeout_Err  output  1  one-cycle pulse: frame abandoned on timeout
- Frame_Count  output  16  frames delivered, wraps 0xFFFF→0x0000

## Operation
- Reset values: Out_Valid=0, Out_Data=0, Seq_Err=0, Timeout_Err=0, Frame_Count=0, state=IDLE, assembly buffer=0. In_Ready evaluates to 1 while in reset.
- Storage: an assembly buffer (NUM_CH×DATA_W) and an output register (Out_Data/Out_Valid).
- FSM states: IDLE, COLLECT. An expected-channel counter `exp` and an idle counter `idle` are used in COLLECT.
- IDLE:
  - Accepted beat with In_Chan=0: store it, exp←1, idle←0, go to COLLECT.
  - Accepted beat with In_Chan≠0: drop it, pulse Seq_Err, stay in IDLE.
- COLLECT, accepted beat:
  - In_Chan==exp: store it at slot exp, exp←exp+1, idle←0.
  - In_Chan==exp==NUM_CH-1: this completes the frame. Load the output register from the buffer plus this beat, set Out_Valid, increment Frame_Count, go to IDLE.
  - In_Chan==0 (with exp≠0): pulse Seq_Err, discard the partial frame, store the beat as slot 0, exp←1, stay in COLLECT.
  - Any other mismatch: pulse Seq_Err, drop the beat and the partial frame, go to IDLE.
- COLLECT, no accepted beat: idle←idle+1. When idle reaches TIMEOUT, pulse Timeout_Err, discard the partial frame, go to IDLE.
- In_Ready = NOT (state==COLLECT AND exp==NUM_CH-1 AND Out_Valid AND NOT Out_Ready).
  - Only the completing beat is back-pressured. All other beats are always accepted.
  - Stalled cycles (In_Valid && !In_Ready) do not advance idle. A stall never causes a timeout.
- Output handshake:
  - Out_Valid clears on Out_Valid && Out_Ready unless a new frame completes in the same cycle. In that case Out_Valid stays 1 and Out_Data takes the new frame.
  - Out_Data is stable while Out_Valid && !Out_Ready.
- Slots in the assembly buffer are not cleared on discard. Every slot is rewritten before any frame is delivered.
- Data passes through unmodified; no arithmetic on samples. Frame_Count is a modulo-2^16 counter.

## Timing
- Latency: the completing beat is accepted at edge N. Out_Valid=1 and the new Out_Data are visible after edge N.
- Throughput: one frame per NUM_CH cycles with continuous beats and Out_Ready held at 1.
- Seq_Err and Timeout_Err are registered and asserted for exactly the one cycle after the causing edge.
- Seq_Err and Timeout_Err are never both asserted: an accepted beat resets idle in the same cycle.
- Asynchronous reset mid-frame: the partial frame is lost, all outputs return to reset values immediately, and after release the block waits in IDLE for channel 0.
- In_Ready is combinational from state, exp, Out_Valid and Out_Ready.

## Structure
- Shared package tdm_pkg:
  - NUM_CH and DATA_W defaults
  - CH_W = $clog2(NUM_CH)
  - state enum {IDLE, COLLECT}
  - frame type (NUM_CH×DATA_W signed array)
  - This package is also used by the transmit-side mux.
- Sub-module tdm_frame_buf: assembly buffer plus output register with the valid/ready hold logic. FSM, counters and error pulses stay in tdm_deframer.

## Test plan
- Continuous beats ch0..3 with data 0x0001, 0xFFFF, 0x7FFF, 0x8000, Out_Ready=1 → Out_Valid for one cycle after ch3. Out_Data={0x8000,0x7FFF,0xFFFF,0x0001}. Frame_Count=1. No errors.
- Beats ch0, ch1, ch3 → Seq_Err pulse on the ch3 beat, no frame. Then ch0..3 delivers a clean frame.
- Beats ch0, ch1, then idle for 15 cycles → Timeout_Err pulse exactly once, no frame. The next ch0..3 sequence succeeds.
- Out_Ready=0 with one frame pending: second frame's ch0..2 accepted, ch3 stalled with In_Ready=0 for 20 cycles, and no Timeout_Err. After Out_Ready=1, frame 1 is taken and frame 2 loads on the same edge.
- Beats ch0, ch1, ch0, ch1, ch2, ch3 → one Seq_Err pulse. The delivered frame holds the second ch0/ch1 values.
- Ex_Rst_n low after ch2 of a frame → all outputs 0 immediately. After release, the beat stream ch3, ch0..3 gives one Seq_Err and then a correct frame with Frame_Count=1.

Source files
------------

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and defaults for the TDM shared-multiplier path
//   (used by both the receive-side deframer and the transmit-side mux).
package tdm_pkg;
   localparam int DEF_NUM_CH = 4;
   localparam int DEF_DATA_W = 16;
   localparam int CH_W = $clog2(DEF_NUM_CH);
   typedef enum logic {IDLE, COLLECT} state_t;
   typedef logic signed [DEF_NUM_CH-1:0][DEF_DATA_W-1:0] frame_t;
endpackage

// File: rtl/tdm_frame_buf.sv
// tdm_frame_buf: assembly buffer plus held output frame register.
//   Clock_20M, Ex_Rst_n : clock, async active-low reset
//   wr, slot, din       : write din into assembly slot
//   complete            : latch buffer (with this write merged) into frame
//   ready               : downstream accept of the held frame
//   valid, frame        : held frame and its valid flag
module tdm_frame_buf import tdm_pkg::*; #(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int DATA_W = DEF_DATA_W,
   localparam int CHW = $clog2(NUM_CH)
) (
   input  logic                       Clock_20M,
   input  logic                       Ex_Rst_n,
   input  logic                       wr,
   input  logic [CHW-1:0]             slot,
   input  logic signed [DATA_W-1:0]   din,
   input  logic                       complete,
   input  logic                       ready,
   output logic                       valid,
   output logic [NUM_CH*DATA_W-1:0]   frame
);
   logic [NUM_CH-1:0][DATA_W-1:0] asm, nxt;
   // The completing beat is merged combinationally so the frame loads on its own edge.
   always_comb begin
      nxt = asm;
      if (wr) nxt[slot] = din;
   end
   always_ff @(posedge Clock_20M or negedge Ex_Rst_n) begin
      if (!Ex_Rst_n) begin
         asm   <= '0;
         valid <= 1'b0;
         frame <= '0;
      end else begin
         if (wr) asm <= nxt;
         if (complete) begin
            frame <= nxt;
            valid <= 1'b1;
         end else if (ready) begin
            valid <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/tdm_deframer.sv
// tdm_deframer: reassembles channel-tagged serial beats into parallel frames.
//   Clock_20M, Ex_Rst_n          : clock, async active-low reset
//   In_Valid/In_Ready            : beat handshake; In_Chan tag, In_Data sample
//   Out_Valid/Out_Ready/Out_Data : frame handshake, channel k at [k*DATA_W +: DATA_W]
//   Seq_Err, Timeout_Err         : one-cycle error pulses
//   Frame_Count                  : frames delivered, modulo 2^16
module tdm_deframer import tdm_pkg::*; #(
   parameter int NUM_CH  = DEF_NUM_CH,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 15,
   localparam int CHW = $clog2(NUM_CH)
) (
   input  logic                       Clock_20M,
   input  logic                       Ex_Rst_n,
   input  logic                       In_Valid,
   output logic                       In_Ready,
   input  logic [CHW-1:0]             In_Chan,
   input  logic signed [DATA_W-1:0]   In_Data,
   output logic                       Out_Valid,
   input  logic                       Out_Ready,
   output logic [NUM_CH*DATA_W-1:0]   Out_Data,
   output logic                       Seq_Err,
   output logic                       Timeout_Err,
   output logic [15:0]                Frame_Count
);
   localparam int IW = $clog2(TIMEOUT + 1);
   state_t         state, state_n;
   logic [CHW-1:0] exp, exp_n, slot;
   logic [IW-1:0]  idle, idle_n;
   logic           seq_n, to_n, wr, complete, accept, last;
   assign last     = (state == COLLECT) && (exp == CHW'(NUM_CH - 1));
   // Only the completing beat can stall, and only while the previous frame is still held.
   assign In_Ready = !(last && Out_Valid && !Out_Ready);
   assign accept   = In_Valid && In_Ready;
   always_comb begin
      state_n  = state;
      exp_n    = exp;
      idle_n   = idle;
      seq_n    = 1'b0;
      to_n     = 1'b0;
      wr       = 1'b0;
      complete = 1'b0;
      slot     = exp;
      if (state == IDLE) begin
         idle_n = '0;
         if (accept) begin
            if (In_Chan == '0) begin
               wr      = 1'b1;
               slot    = '0;
               exp_n   = CHW'(1);
               state_n = COLLECT;
            end else begin
               seq_n = 1'b1;
            end
         end
      end else if (accept) begin
         idle_n = '0;
         if (In_Chan == exp) begin
            wr       = 1'b1;
            complete = last;
            exp_n    = last ? '0 : exp + CHW'(1);
            state_n  = last ? IDLE : COLLECT;
         end else if (In_Chan == '0) begin
            seq_n = 1'b1;
            wr    = 1'b1;
            slot  = '0;
            exp_n = CHW'(1);
         end else begin
            seq_n   = 1'b1;
            exp_n   = '0;
            state_n = IDLE;
         end
      end else if (!In_Valid) begin
         // A stalled beat holds idle; only genuinely empty cycles count toward timeout.
         if (idle == IW'(TIMEOUT - 1)) begin
            to_n    = 1'b1;
            idle_n  = '0;
            exp_n   = '0;
            state_n = IDLE;
         end else begin
            idle_n = idle + IW'(1);
         end
      end
   end
   always_ff @(posedge Clock_20M or negedge Ex_Rst_n) begin
      if (!Ex_Rst_n) begin
         state       <= IDLE;
         exp         <= '0;
         idle        <= '0;
         Seq_Err     <= 1'b0;
         Timeout_Err <= 1'b0;
         Frame_Count <= '0;
      end else begin
         state       <= state_n;
         exp         <= exp_n;
         idle        <= idle_n;
         Seq_Err     <= seq_n;
         Timeout_Err <= to_n;
         if (complete) Frame_Count <= Frame_Count + 16'd1;
      end
   end
   tdm_frame_buf #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) u_buf (
      .Clock_20M (Clock_20M),
      .Ex_Rst_n  (Ex_Rst_n),
      .wr        (wr),
      .slot      (slot),
      .din       (In_Data),
      .complete  (complete),
      .ready     (Out_Ready),
      .valid     (Out_Valid),
      .frame     (Out_Data)
   );
endmodule

// File: tb/tb_tdm_deframer.sv
// tb_tdm_deframer: directed plus random stimulus against a queue-based frame model.
module tb_tdm_deframer;
   localparam int NC = 4;
   localparam int TO = 15;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        iv = 1'b0;
   logic        ordy = 1'b0;
   logic [1:0]  ich = '0;
   logic signed [15:0] idata = '0;
   logic        in_ready, out_valid, seq_err, to_err;
   logic [63:0] out_data;
   logic [15:0] frame_count;
   int checks = 0;
   int failures = 0;
   logic [15:0] part[$];
   logic [63:0] pd = '0;
   logic        pv = 1'b0;
   logic [15:0] fc = '0;
   logic        se = 1'b0;
   logic        te = 1'b0;
   int          idle = 0;
   tdm_deframer #(.NUM_CH(NC), .DATA_W(16), .TIMEOUT(TO)) dut (
      .Clock_20M   (clk),
      .Ex_Rst_n    (rst_n),
      .In_Valid    (iv),
      .In_Ready    (in_ready),
      .In_Chan     (ich),
      .In_Data     (idata),
      .Out_Valid   (out_valid),
      .Out_Ready   (ordy),
      .Out_Data    (out_data),
      .Seq_Err     (seq_err),
      .Timeout_Err (to_err),
      .Frame_Count (frame_count)
   );
   always #25 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      assert (got === want) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
      end
   endtask
   task automatic check_outputs();
      chk("out_valid", {63'd0, out_valid}, {63'd0, pv});
      chk("out_data", out_data, pd);
      chk("seq_err", {63'd0, seq_err}, {63'd0, se});
      chk("timeout_err", {63'd0, to_err}, {63'd0, te});
      chk("frame_count", {48'd0, frame_count}, {48'd0, fc});
   endtask
   // One cycle: drive inputs, check In_Ready, advance model, clock, check outputs.
   task automatic step(input logic v, input logic [1:0] ch, input logic [15:0] d, input logic r);
      logic rdy, acc, done;
      logic [63:0] nf;
      iv = v; ich = ch; idata = d; ordy = r;
      #1;
      rdy = !(part.size() == NC - 1 && pv && !r);
      chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
      acc = v && rdy;
      done = 1'b0;
      nf = '0;
      se = 1'b0;
      te = 1'b0;
      if (acc) begin
         idle = 0;
         if (int'(ch) == part.size()) begin
            part.push_back(d);
            if (part.size() == NC) begin
               done = 1'b1;
               for (int i = 0; i < NC; i++) nf[i*16 +: 16] = part[i];
               part.delete();
            end
         end else if (ch == 2'd0) begin
            se = 1'b1;
            part.delete();
            part.push_back(d);
         end else begin
            se = 1'b1;
            part.delete();
         end
      end else if (!v && part.size() > 0) begin
         idle++;
         if (idle == TO) begin
            te = 1'b1;
            idle = 0;
            part.delete();
         end
      end
      if (done) begin
         pv = 1'b1;
         pd = nf;
         fc = fc + 16'd1;
      end else if (pv && r) begin
         pv = 1'b0;
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask
   task automatic frame(input logic r);
      for (int i = 0; i < NC; i++) step(1'b1, 2'(i), 16'($urandom), r);
   endtask
   initial begin
      logic [1:0] c;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check_outputs();
      rst_n = 1'b1;
      step(1'b1, 2'd0, 16'h0001, 1'b1);
      step(1'b1, 2'd1, 16'hFFFF, 1'b1);
      step(1'b1, 2'd2, 16'h7FFF, 1'b1);
      step(1'b1, 2'd3, 16'h8000, 1'b1);
      chk("frame1_data", out_data, 64'h8000_7FFF_FFFF_0001);
      chk("frame1_count", {48'd0, frame_count}, 64'd1);
      step(1'b0, 2'd0, 16'h0, 1'b1);
      step(1'b1, 2'd0, 16'h1111, 1'b1);
      step(1'b1, 2'd1, 16'h2222, 1'b1);
      step(1'b1, 2'd3, 16'h3333, 1'b1);
      chk("skip_seq_err", {63'd0, seq_err}, 64'd1);
      frame(1'b1);
      step(1'b1, 2'd0, 16'h0A0A, 1'b1);
      step(1'b1, 2'd1, 16'h0B0B, 1'b1);
      repeat (TO) step(1'b0, 2'd0, 16'h0, 1'b1);
      chk("timeout_pulse", {63'd0, to_err}, 64'd1);
      step(1'b0, 2'd0, 16'h0, 1'b1);
      frame(1'b1);
      step(1'b0, 2'd0, 16'h0, 1'b0);
      frame(1'b0);
      for (int i = 0; i < NC - 1; i++) step(1'b1, 2'(i), 16'($urandom), 1'b0);
      repeat (20) step(1'b1, 2'd3, 16'h5A5A, 1'b0);
      chk("stall_ready", {63'd0, in_ready}, 64'd0);
      step(1'b1, 2'd3, 16'h5A5A, 1'b1);
      chk("stall_frame2", {48'd0, out_data[63:48]}, 64'h5A5A);
      step(1'b0, 2'd0, 16'h0, 1'b1);
      step(1'b1, 2'd0, 16'hC000, 1'b1);
      step(1'b1, 2'd1, 16'hC001, 1'b1);
      step(1'b1, 2'd0, 16'hD000, 1'b1);
      step(1'b1, 2'd1, 16'hD001, 1'b1);
      step(1'b1, 2'd2, 16'hD002, 1'b1);
      step(1'b1, 2'd3, 16'hD003, 1'b1);
      chk("restart_frame", out_data, 64'hD003_D002_D001_D000);
      for (int i = 0; i < NC - 1; i++) step(1'b1, 2'(i), 16'($urandom), 1'b1);
      iv = 1'b0;
      rst_n = 1'b0;
      #1;
      part.delete();
      pv = 1'b0; pd = '0; fc = '0; se = 1'b0; te = 1'b0; idle = 0;
      chk("async_rst_ready", {63'd0, in_ready}, 64'd1);
      check_outputs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b1, 2'd3, 16'h7777, 1'b1);
      chk("post_rst_seq", {63'd0, seq_err}, 64'd1);
      frame(1'b1);
      chk("post_rst_count", {48'd0, frame_count}, 64'd1);
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 49) == 0) begin
            repeat (TO + 1) step(1'b0, 2'd0, 16'h0, 1'($urandom_range(0, 1)));
         end else begin
            c = ($urandom_range(0, 9) < 8) ? 2'(part.size()) : 2'($urandom_range(0, 3));
            step(1'($urandom_range(0, 9) < 7), c, 16'($urandom), 1'($urandom_range(0, 3) != 0));
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
